voting_ctrl: RTL and testbench

VOTING_CTRL -- requirements
Module: voting_ctrl

---
 rtl/voting_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_voting_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/voting_ctrl.sv
// Round-robin ballot collector: grants one voter per cycle, tallies ballots per candidate,
// then scans the tallies one candidate per cycle to pick the winner (lowest index on ties).
module voting_ctrl #(
    parameter int NUM_VOTERS = 8,
    parameter int CAND_BITS  = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            close,
    input  logic [NUM_VOTERS-1:0]           req,
    input  logic [NUM_VOTERS*CAND_BITS-1:0] ballot,
    output logic [NUM_VOTERS-1:0]           grant,
    output logic [NUM_VOTERS-1:0]           voted,
    output logic                            busy,
    output logic                            done,
    output logic [CAND_BITS-1:0]            winner,
    output logic [$clog2(NUM_VOTERS):0]     win_count,
    output logic                            dup_req
);

    localparam int NUM_CANDS = 2**CAND_BITS;
    localparam int PTR_W     = $clog2(NUM_VOTERS);
    localparam int CNT_W     = $clog2(NUM_VOTERS) + 1;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        COMPARE,
        DONE
    } state_t;

    state_t                  state_q;
    state_t                  state_d;

    logic [CNT_W-1:0]        tally_q [NUM_CANDS];
    logic [NUM_VOTERS-1:0]   voted_q;
    logic [PTR_W-1:0]        rr_ptr_q;
    logic [CNT_W-1:0]        best_count_q;
    logic [CAND_BITS-1:0]    best_idx_q;
    logic [CAND_BITS-1:0]    cmp_idx_q;
    logic [CAND_BITS-1:0]    winner_q;
    logic [CNT_W-1:0]        win_count_q;
    logic                    dup_q;

    logic [NUM_VOTERS-1:0]   eligible;
    logic                    grant_valid;
    logic [PTR_W-1:0]        grant_idx;
    logic [PTR_W-1:0]        search_idx;
    logic [CAND_BITS-1:0]    granted_ballot;
    logic                    all_voted;
    logic                    cmp_last;
    logic [CNT_W-1:0]        cand_count;
    logic                    cand_take;
    logic [CNT_W-1:0]        next_best_count;
    logic [CAND_BITS-1:0]    next_best_idx;

    assign eligible = req & ~voted_q;

    // Round-robin search starting at rr_ptr_q; the pointer width makes the wrap free.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        search_idx  = '0;
        if (state_q == COLLECT) begin
            for (int i = 0; i < NUM_VOTERS; i++) begin
                search_idx = rr_ptr_q + PTR_W'(i);
                if (!grant_valid && eligible[search_idx]) begin
                    grant_valid = 1'b1;
                    grant_idx   = search_idx;
                end
            end
            if (grant_valid) begin
                grant[grant_idx] = 1'b1;
            end
        end
    end

    always_comb begin
        granted_ballot = '0;
        for (int i = 0; i < NUM_VOTERS; i++) begin
            if (grant[i]) begin
                granted_ballot = ballot[i*CAND_BITS +: CAND_BITS];
            end
        end
    end

    assign all_voted = grant_valid && (&(voted_q | grant));
    assign cmp_last  = &cmp_idx_q;

    // Strict comparison keeps the earliest (lowest-index) candidate on a tie.
    assign cand_count      = tally_q[cmp_idx_q];
    assign cand_take       = (cmp_idx_q == '0) || (cand_count > best_count_q);
    assign next_best_count = cand_take ? cand_count : best_count_q;
    assign next_best_idx   = cand_take ? cmp_idx_q  : best_idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (close || all_voted) begin
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (cmp_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_d = COLLECT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Tallies cannot wrap: each voter is counted once and CNT_W holds NUM_VOTERS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CANDS; c++) begin
                tally_q[c] <= '0;
            end
            voted_q      <= '0;
            rr_ptr_q     <= '0;
            best_count_q <= '0;
            best_idx_q   <= '0;
            cmp_idx_q    <= '0;
            winner_q     <= '0;
            win_count_q  <= '0;
            dup_q        <= 1'b0;
        end else begin
            dup_q <= (state_q == COLLECT) && (|(req & voted_q));
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        for (int c = 0; c < NUM_CANDS; c++) begin
                            tally_q[c] <= '0;
                        end
                        voted_q      <= '0;
                        rr_ptr_q     <= '0;
                        best_count_q <= '0;
                        best_idx_q   <= '0;
                        cmp_idx_q    <= '0;
                        winner_q     <= '0;
                        win_count_q  <= '0;
                    end
                end
                COLLECT: begin
                    if (grant_valid) begin
                        tally_q[granted_ballot] <= tally_q[granted_ballot] + CNT_W'(1);
                        voted_q                 <= voted_q | grant;
                        rr_ptr_q                <= grant_idx + PTR_W'(1);
                    end
                end
                COMPARE: begin
                    best_count_q <= next_best_count;
                    best_idx_q   <= next_best_idx;
                    cmp_idx_q    <= cmp_idx_q + CAND_BITS'(1);
                    if (cmp_last) begin
                        winner_q    <= next_best_idx;
                        win_count_q <= next_best_count;
                    end
                end
                default: ;
            endcase
        end
    end

    assign voted     = voted_q;
    assign busy      = (state_q == COLLECT) || (state_q == COMPARE);
    assign done      = (state_q == DONE);
    assign winner    = winner_q;
    assign win_count = win_count_q;
    assign dup_req   = dup_q;

endmodule

// File: tb/tb_voting_ctrl.sv
// Self-checking bench for voting_ctrl: directed election scenarios plus random traffic,
// all compared cycle by cycle against an election model built from plain counters and arrays.
module tb_voting_ctrl;

    localparam int NV = 8;
    localparam int CB = 2;
    localparam int NC = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic                close;
    logic [NV-1:0]       req;
    logic [NV*CB-1:0]    ballot;
    logic [NV-1:0]       grant;
    logic [NV-1:0]       voted;
    logic                busy;
    logic                done;
    logic [CB-1:0]       winner;
    logic [3:0]          win_count;
    logic                dup_req;

    voting_ctrl #(.NUM_VOTERS(NV), .CAND_BITS(CB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .close     (close),
        .req       (req),
        .ballot    (ballot),
        .grant     (grant),
        .voted     (voted),
        .busy      (busy),
        .done      (done),
        .winner    (winner),
        .win_count (win_count),
        .dup_req   (dup_req)
    );

    always #5 clk = ~clk;

    // Election model: phase 0 idle, 1 collecting, 2 counting down the scan, 3 result ready.
    int            m_phase;
    logic [NV-1:0] m_voted;
    int            m_rr;
    int            m_tally [NC];
    logic          m_dup;
    int            m_scan_left;
    int            m_winner;
    int            m_count;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_phase     = 0;
        m_voted     = '0;
        m_rr        = 0;
        m_dup       = 1'b0;
        m_scan_left = 0;
        m_winner    = 0;
        m_count     = 0;
        for (int c = 0; c < NC; c++) m_tally[c] = 0;
    endtask

    function automatic int ballotOf(input int v);
        logic [CB-1:0] b;
        b = ballot[v*CB +: CB];
        return int'(b);
    endfunction

    function automatic int expectedGrant();
        if (m_phase != 1) return -1;
        for (int k = 0; k < NV; k++) begin
            int v;
            v = (m_rr + k) % NV;
            if (req[v] && !m_voted[v]) return v;
        end
        return -1;
    endfunction

    task automatic modelEdge(input int g);
        case (m_phase)
            0, 3: begin
                m_dup = 1'b0;
                if (start) begin
                    m_phase = 1;
                    m_voted = '0;
                    m_rr    = 0;
                    for (int c = 0; c < NC; c++) m_tally[c] = 0;
                end
            end
            1: begin
                m_dup = |(req & m_voted);
                if (g >= 0) begin
                    m_tally[ballotOf(g)]++;
                    m_voted[g] = 1'b1;
                    m_rr       = (g + 1) % NV;
                end
                if (close || m_voted == '1) begin
                    m_phase     = 2;
                    m_scan_left = NC;
                    m_winner    = 0;
                    m_count     = m_tally[0];
                    for (int c = 1; c < NC; c++) begin
                        if (m_tally[c] > m_count) begin
                            m_winner = c;
                            m_count  = m_tally[c];
                        end
                    end
                end
            end
            default: begin
                m_dup = 1'b0;
                m_scan_left--;
                if (m_scan_left == 0) m_phase = 3;
            end
        endcase
    endtask

    // One clock: grant is checked before the edge, registered outputs just after it.
    task automatic tick();
        int g;
        logic [31:0] exp_grant;
        #1;
        g = expectedGrant();
        exp_grant = (g >= 0) ? (32'd1 << g) : 32'd0;
        checkOutput("grant", grant, exp_grant);
        @(posedge clk);
        modelEdge(g);
        #1;
        checkOutput("voted", voted, m_voted);
        checkOutput("dup_req", dup_req, m_dup);
        checkOutput("busy", busy, (m_phase == 1 || m_phase == 2));
        checkOutput("done", done, (m_phase == 3));
        if (m_phase == 3) begin
            checkOutput("winner", winner, m_winner);
            checkOutput("win_count", win_count, m_count);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic c, input logic [NV-1:0] r,
                                 input logic [NV*CB-1:0] b);
        start  = s;
        close  = c;
        req    = r;
        ballot = b;
        tick();
    endtask

    task automatic runUntilDone(input string tag, input int budget, input int exp_cycles);
        int cycles;
        cycles = 0;
        start  = 1'b0;
        close  = 1'b0;
        while (done !== 1'b1 && cycles < budget) begin
            tick();
            cycles++;
        end
        checkOutput(tag, cycles, exp_cycles);
    endtask

    localparam logic [NV*CB-1:0] BALLOTS_A   = {2'd1, 2'd0, 2'd3, 2'd1, 2'd2, 2'd1, 2'd1, 2'd0};
    localparam logic [NV*CB-1:0] BALLOTS_TIE = {2'd1, 2'd0, 2'd1, 2'd0, 2'd3, 2'd3, 2'd2, 2'd2};

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        close  = 1'b0;
        req    = '0;
        ballot = '0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_voted", voted, 0);
        checkOutput("rst_dup", dup_req, 0);
        checkOutput("rst_winner", winner, 0);
        checkOutput("rst_win_count", win_count, 0);
        rst_n = 1'b1;

        $display("[TB] idle with requests but no start");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 8'hFF, BALLOTS_A);

        $display("[TB] full election, all voters requesting");
        applyStimulus(1'b1, 1'b0, 8'hFF, BALLOTS_A);
        runUntilDone("full_latency", 40, 12);
        checkOutput("full_winner", winner, 1);
        checkOutput("full_win_count", win_count, 4);
        checkOutput("full_voted", voted, 8'hFF);

        $display("[TB] four-way tie");
        applyStimulus(1'b1, 1'b0, 8'hFF, BALLOTS_TIE);
        runUntilDone("tie_latency", 40, 12);
        checkOutput("tie_winner", winner, 0);
        checkOutput("tie_win_count", win_count, 2);

        $display("[TB] single voter holding its request");
        applyStimulus(1'b1, 1'b0, 8'h00, 16'h0C00);
        applyStimulus(1'b0, 1'b0, 8'h20, 16'h0C00);
        checkOutput("single_dup_first", dup_req, 0);
        applyStimulus(1'b0, 1'b0, 8'h20, 16'h0C00);
        checkOutput("single_dup_second", dup_req, 1);
        applyStimulus(1'b0, 1'b1, 8'h20, 16'h0C00);
        runUntilDone("single_latency", 20, 4);
        checkOutput("single_voted", voted, 8'h20);
        checkOutput("single_winner", winner, 3);
        checkOutput("single_win_count", win_count, 1);

        $display("[TB] round-robin after voter 6");
        applyStimulus(1'b1, 1'b0, 8'h00, BALLOTS_A);
        applyStimulus(1'b0, 1'b0, 8'h40, BALLOTS_A);
        req = 8'h42;
        #1;
        checkOutput("rr_grant_voter1", grant, 8'h02);
        tick();
        #1;
        checkOutput("rr_no_regrant", grant, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'h42, BALLOTS_A);
        runUntilDone("rr_latency", 20, 4);
        checkOutput("rr_voted", voted, 8'h42);

        $display("[TB] reset in the middle of the candidate scan");
        applyStimulus(1'b1, 1'b0, 8'hFF, BALLOTS_TIE);
        for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b0, 8'hFF, BALLOTS_TIE);
        checkOutput("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("async_busy", busy, 0);
        checkOutput("async_done", done, 0);
        checkOutput("async_voted", voted, 0);
        checkOutput("async_dup", dup_req, 0);
        checkOutput("async_winner", winner, 0);
        checkOutput("async_win_count", win_count, 0);
        checkOutput("async_grant", grant, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 8'hFF, BALLOTS_A);
        applyStimulus(1'b1, 1'b0, 8'hFF, BALLOTS_A);
        runUntilDone("restart_latency", 40, 12);
        checkOutput("restart_winner", winner, 1);
        checkOutput("restart_win_count", win_count, 4);

        $display("[TB] empty election closed at once");
        applyStimulus(1'b1, 1'b0, 8'h00, BALLOTS_A);
        applyStimulus(1'b0, 1'b1, 8'h00, BALLOTS_A);
        runUntilDone("empty_latency", 20, 4);
        checkOutput("empty_winner", winner, 0);
        checkOutput("empty_win_count", win_count, 0);

        $display("[TB] random traffic");
        for (int i = 0; i < 800; i++) begin
            applyStimulus(($urandom_range(0, 5) == 0), ($urandom_range(0, 11) == 0),
                          8'($urandom) & 8'($urandom), 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
